// File: rtl/br_wr_ctrl.sv
// rtl/br_wr_ctrl.sv - write-port controller for the 32x32 register file: reset clear sweep, round-robin A/B writes
// Optional read-port forwarding of the in-flight write under `BR_WR_CTRL_BYPASS_EN.
module br_wr_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          br_we3,
  output logic [AW-1:0] br_wa3,
  output logic [DW-1:0] br_wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [AW-1:0] br_ra1,
  output logic [AW-1:0] br_ra2,
  input  logic [DW-1:0] br_rd1,
  input  logic [DW-1:0] br_rd2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          last_b;   // 1: B was granted most recently
  logic          in_run;

  assign in_run  = (state == S_RUN);
  assign busy    = ~in_run;
  assign a_ready = in_run & a_valid & (~b_valid | last_b);
  assign b_ready = in_run & b_valid & (~a_valid | ~last_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_INIT;
      cnt    <= CNT_ONE;
      last_b <= 1'b1;
      br_we3 <= 1'b0;
      br_wa3 <= '0;
      br_wd3 <= '0;
    end else if (state == S_INIT) begin
      br_we3 <= 1'b1;
      br_wa3 <= cnt;
      br_wd3 <= '0;
      if (cnt == CNT_LAST) begin
        state <= S_RUN;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end else if (a_ready) begin
      // x0 is hard-wired: accept the request but never enable the write
      br_we3 <= (a_addr != ADDR_ZERO);
      br_wa3 <= a_addr;
      br_wd3 <= a_data;
      last_b <= 1'b0;
    end else if (b_ready) begin
      br_we3 <= (b_addr != ADDR_ZERO);
      br_wa3 <= b_addr;
      br_wd3 <= b_data;
      last_b <= 1'b1;
    end else begin
      br_we3 <= 1'b0;
    end
  end

  assign br_ra1 = ra1;
  assign br_ra2 = ra2;

`ifdef BR_WR_CTRL_BYPASS_EN
  // Forward the registered write so a read sees it one cycle before BR commits it
  assign rd1 = (br_we3 && (ra1 == br_wa3) && (ra1 != ADDR_ZERO)) ? br_wd3 : br_rd1;
  assign rd2 = (br_we3 && (ra2 == br_wa3) && (ra2 != ADDR_ZERO)) ? br_wd3 : br_rd2;
`else
  assign rd1 = br_rd1;
  assign rd2 = br_rd2;
`endif

endmodule

// File: tb/tb_br_wr_ctrl.sv
// tb/tb_br_wr_ctrl.sv - directed bench for br_wr_ctrl with a behavioural 32x32 BR model
module tb_br_wr_ctrl;

`ifdef BR_WR_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        br_we3;
  logic [4:0]  br_wa3;
  logic [31:0] br_wd3;
  logic [4:0]  ra1, ra2, br_ra1, br_ra2;
  logic [31:0] br_rd1, br_rd2, rd1, rd2;
  logic        busy;
  logic        preload;
  logic [31:0] rf [32];

  int pass_cnt = 0;
  int total_cnt = 0;

  br_wr_ctrl #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .br_we3(br_we3), .br_wa3(br_wa3), .br_wd3(br_wd3),
    .ra1(ra1), .ra2(ra2), .br_ra1(br_ra1), .br_ra2(br_ra2),
    .br_rd1(br_rd1), .br_rd2(br_rd2), .rd1(rd1), .rd2(rd2),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BR model: garbage preload so the clear sweep is observable, x0 reads 0
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA5A5_0000 | i;
    end else if (br_we3) begin
      rf[br_wa3] <= br_wd3;
    end
  end
  assign br_rd1 = (br_ra1 == 5'd0) ? 32'd0 : rf[br_ra1];
  assign br_rd2 = (br_ra2 == 5'd0) ? 32'd0 : rf[br_ra2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check();
    for (int i = 1; i <= 31; i++) begin
      step();
      chk($sformatf("sweep_we_%0d", i), {31'd0, br_we3}, 32'd1);
      chk($sformatf("sweep_wa_%0d", i), {27'd0, br_wa3}, i);
      chk($sformatf("sweep_wd_%0d", i), br_wd3, 32'd0);
      chk($sformatf("sweep_busy_%0d", i), {31'd0, busy}, (i < 31) ? 32'd1 : 32'd0);
      if (i == 2) begin
        chk("init_a_ready_ignored", {31'd0, a_ready}, 32'd0);
        chk("init_b_ready_ignored", {31'd0, b_ready}, 32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 5'd9; b_addr = 5'd12; a_data = 32'h1111; b_data = 32'h2222;
    ra1 = 5'd0; ra2 = 5'd0;
    step(); step();
    preload = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_we", {31'd0, br_we3}, 32'd0);
    chk("rst_wa", {27'd0, br_wa3}, 32'd0);
    chk("rst_wd", br_wd3, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("pre_sweep_x7", rf[7], 32'hA5A5_0007);

    rst_n = 1'b1;
    sweep_check();
    step();
    chk("post_sweep_we", {31'd0, br_we3}, 32'd0);
    chk("post_sweep_busy", {31'd0, busy}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk($sformatf("clear_rd1_x%0d", i), rd1, 32'd0);
      chk($sformatf("clear_rd2_x%0d", 31 - i), rd2, 32'd0);
    end

    // single requester A: x5 = 42
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'd42; ra1 = 5'd5;
    #1;
    chk("single_a_ready", {31'd0, a_ready}, 32'd1);
    chk("single_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    a_valid = 1'b0;
    chk("single_we", {31'd0, br_we3}, 32'd1);
    chk("single_wa", {27'd0, br_wa3}, 32'd5);
    chk("single_wd", br_wd3, 32'd42);
    chk("single_rd1_n1", rd1, BYP ? 32'd42 : 32'd0);
    step();
    chk("single_idle_we", {31'd0, br_we3}, 32'd0);
    chk("single_hold_wa", {27'd0, br_wa3}, 32'd5);
    chk("single_hold_wd", br_wd3, 32'd42);
    chk("single_rd1_n2", rd1, 32'd42);

    // B writes x0: accepted, write dropped
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF; ra2 = 5'd0;
    #1;
    chk("x0_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    chk("x0_we", {31'd0, br_we3}, 32'd0);
    chk("x0_wa", {27'd0, br_wa3}, 32'd0);
    chk("x0_wd", br_wd3, 32'hFFFF_FFFF);
    chk("x0_rd2", rd2, 32'd0);
    step();
    chk("x0_rd2_later", rd2, 32'd0);

    // contention: A x10=99, B x11=7, held two cycles
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'd99;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'd7;
    #1;
    chk("cont1_a_ready", {31'd0, a_ready}, 32'd1);
    chk("cont1_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    chk("cont1_wa", {27'd0, br_wa3}, 32'd10);
    chk("cont1_wd", br_wd3, 32'd99);
    chk("cont2_a_ready", {31'd0, a_ready}, 32'd0);
    chk("cont2_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    chk("cont2_we", {31'd0, br_we3}, 32'd1);
    chk("cont2_wa", {27'd0, br_wa3}, 32'd11);
    chk("cont2_wd", br_wd3, 32'd7);

    for (int k = 0; k < 4; k++) begin
      a_data = 32'(100 + k);
      b_data = 32'(200 + k);
      #1;
      chk($sformatf("alt%0d_a_ready", k), {31'd0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_b_ready", k), {31'd0, b_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk($sformatf("alt%0d_wa", k), {27'd0, br_wa3}, (k % 2 == 0) ? 32'd10 : 32'd11);
      chk($sformatf("alt%0d_wd", k), br_wd3, (k % 2 == 0) ? 32'(100 + k) : 32'(200 + k));
    end
    a_valid = 1'b0; b_valid = 1'b0;
    ra1 = 5'd10; ra2 = 5'd11;
    step();
    chk("alt_x10", rd1, 32'd102);
    chk("alt_x11", rd2, 32'd203);

    // x3 = 0xDEAD with ra1=3, ra2=0
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEAD; ra1 = 5'd3; ra2 = 5'd0;
    step();
    a_valid = 1'b0;
    chk("byp_rd1", rd1, BYP ? 32'hDEAD : 32'd0);
    chk("byp_rd2", rd2, 32'd0);
    step();
    chk("byp_rd1_commit", rd1, 32'hDEAD);

    // reset while x7=123 is pending
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'd123; ra1 = 5'd7;
    step();
    a_valid = 1'b0;
    chk("rstmid_we_before", {31'd0, br_we3}, 32'd1);
    chk("rstmid_wa_before", {27'd0, br_wa3}, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("rstmid_we_async", {31'd0, br_we3}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd1);
    step();
    chk("rstmid_x7_not_written", rf[7], 32'd0);
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    sweep_check();
    step();
    chk("rstmid_post_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_x7_rd", rd1, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/br_wr_ctrl.md
# br_wr_ctrl

Write-port controller for the 32×32 register file (`BR`). It sits between the core's two writeback sources and `BR`:
- requester A: ALU result
- requester B: load data

After reset it sequences a zero-clear sweep of x1..x31. It then arbitrates the single write port round-robin and drives `BR` write signals from registers. Optionally it forwards the in-flight write onto the read ports.

## Interface
- `DW`, 32, data width
- `AW`, 5, register address width (2^AW registers)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  requester A write request
- `a_ready`  out  1  A accepted this cycle
- `a_addr`  in  AW  A destination register
- `a_data`  in  DW  A write data
- `b_valid`, `b_ready`, `b_addr`, `b_data`  same as A, for requester B
- `br_we3`  out  1  `BR` write enable (registered)
- `br_wa3`  out  AW  `BR` write address (registered)
- `br_wd3`  out  DW  `BR` write data (registered)
- `ra1`, `ra2`  in  AW  core read addresses
- `br_ra1`, `br_ra2`  out  AW  to `BR` read ports; combinational copies of `ra1` and `ra2`
- `br_rd1`, `br_rd2`  in  DW  from `BR` read ports
- `rd1`, `rd2`  out  DW  read data to core
- `busy`  out  1  high while the clear sweep runs

## Operation
States:
- INIT: clear sweep.
  - Counter `cnt` (AW bits) starts at 1 and increments by 1 per cycle.
  - Each cycle registers the write {we=1, wa=cnt, wd=0}.
  - When `cnt`=31 is registered, `cnt` stays 31 and the state moves to RUN.
  - `busy`=1; `a_ready`=`b_ready`=0.
- RUN:
  - Grant rules:
    - Only A valid: grant A.
    - Only B valid: grant B.
    - Both valid: grant the requester that was not granted last.
  - `last` pointer updates only on a grant.
  - `x_ready` = grant to x. Ready is combinational from the valids and `last`.
  - A handshake (valid & ready) registers {we=1, wa=addr, wd=data} at the same edge.
  - Handshake with addr=0: accepted, but registers we=0 (write dropped). `br_wa3` and `br_wd3` still load the request values.
  - No handshake: registers we=0; `br_wa3` and `br_wd3` hold their values.
  - One write per cycle; there is no queue, so back-to-back grants are allowed every cycle.
- Reset values: state=INIT, `cnt`=1, `last`=B (so A wins the first tie), `br_we3`=0, `br_wa3`=0, `br_wd3`=0, `busy`=1.
- Reset asserted mid-operation:
  - Registered write is cleared immediately (asynchronously); it is not committed.
  - Sweep restarts from x1 after release.
- Valids asserted during INIT are ignored (ready=0). Requesters must hold valid/addr/data until ready.

## Timing
- Sweep: rising edges 1..31 after `rst_n` release register writes to x1..x31.
  - `BR` commits each write one edge later; the x31 write commits at edge 32.
  - `busy` falls and RUN starts after edge 31; ready can first be high in cycle 32.
- Write latency: handshake at edge N → `br_we3`=1 during cycle N..N+1 → `BR` commits at edge N+1.
- Read path (no bypass): `rd1` = `br_rd1` and `rd2` = `br_rd2`, combinational, zero latency.
- A read of a register written by a handshake at edge N returns the new value:
  - from cycle N+1 with bypass;
  - from cycle N+2 without bypass.

## Configuration
- `BR_WR_CTRL_BYPASS_EN` defined: forwarding on each read port.
  - rd1 = `br_wd3` when `br_we3`=1 and `ra1`==`br_wa3` and `ra1`≠0; otherwise `br_rd1`. Same rule for rd2.
  - Forwarding also applies during INIT, so swept registers read 0 one cycle early.
- Not defined: `rd1`/`rd2` are pure pass-through of `br_rd1`/`br_rd2`; no comparators are instantiated.

## Test plan
- Reset release, no requests:
  - `busy`=1 for 31 cycles.
  - `br_wa3` steps 1..31 with `br_wd3`=0 and `br_we3`=1.
  - Then `busy`=0 and `br_we3`=0; every register reads 0.
- Single requester: A writes x5=42 in cycle 40:
  - `a_ready`=1 same cycle.
  - Next cycle `br_we3`=1, `br_wa3`=5, `br_wd3`=42.
  - Reading x5 returns 42 from two cycles after the handshake (one cycle with `BR_WR_CTRL_BYPASS_EN`).
- Contention: A (x10=99) and B (x11=7) valid and held for 2 cycles:
  - Cycle 1 grants A, cycle 2 grants B.
  - With both valid for 4 cycles, grants alternate A,B,A,B.
- Write to x0: B writes x0=0xFFFFFFFF → `b_ready`=1, `br_we3` stays 0, x0 reads 0.
- Reset mid-write: assert `rst_n`=0 while `br_we3`=1 (x7=123 pending):
  - `br_we3` drops to 0 immediately; x7 is not written.
  - After release the sweep reruns and x7 reads 0.
- Bypass build: handshake writes x3=0xDEAD with `ra1`=3 and `ra2`=0:
  - `rd1`=0xDEAD in the cycle after the handshake.
  - `rd2`=`br_rd2`=0 (no forwarding for address 0).
